mem_sx: RTL and testbench

Load-data sign/zero extension unit for the RV32I datapath. It sits between the data memory read port and the register-file write-back mux. It takes the raw 32-bit word read from memory and the load's funct3 code, selects the low byte, halfword or whole word, and extends the selection to 32 bits with either sign or zero fill. The result is registered once.

---
 rtl/mem_sx.sv | 67 ++++++
 tb/tb_mem_sx.sv | 138 +++++++++++++
 2 files changed

// File: rtl/mem_sx.sv
// -----------------------------------------------------------------------------
// mem_sx : RV32I load-data sign/zero extension unit
//
// This unit sits between the data-memory read port and the register-file
// write-back mux. It picks the low byte, the low halfword or the whole word of
// the raw memory word, as selected by the load funct3 code. It then sign- or
// zero-extends that field to 32 bits and registers the result once.
//
// Ports
//   clk        in   1   system clock
//   reset      in   1   synchronous active-high reset; forces mem_extend to 0
//   mem_size   in   3   load funct3: 0=LB 1=LH 2=LW 4=LBU 5=LHU
//   mem_value  in  32   raw memory data, byte/half already right-aligned
//   mem_extend out 32   extended load result, one cycle after the inputs
//
// Build option
//   MEMSX_ILLEGAL_ZERO_EN : when defined, the illegal codes 3, 6 and 7
//                           register zero. When undefined, they pass
//                           mem_value through unchanged, the same as LW.
// -----------------------------------------------------------------------------
module mem_sx (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  mem_size,
   input  logic [31:0] mem_value,
   output logic [31:0] mem_extend
);

   localparam logic [2:0] SZ_LB  = 3'd0;
   localparam logic [2:0] SZ_LH  = 3'd1;
   localparam logic [2:0] SZ_LW  = 3'd2;
   localparam logic [2:0] SZ_LBU = 3'd4;
   localparam logic [2:0] SZ_LHU = 3'd5;

   logic [31:0] w_ext_next;
   logic [31:0] r_ext_reg;

   // Only the selected field is read. Upper bits of mem_value are ignored
   // for byte and half loads.
   always_comb begin
      w_ext_next = mem_value;
      case (mem_size)
         SZ_LB:   w_ext_next = {{24{mem_value[7]}},  mem_value[7:0]};
         SZ_LH:   w_ext_next = {{16{mem_value[15]}}, mem_value[15:0]};
         SZ_LW:   w_ext_next = mem_value;
         SZ_LBU:  w_ext_next = {24'h00_0000, mem_value[7:0]};
         SZ_LHU:  w_ext_next = {16'h0000,    mem_value[15:0]};
`ifdef MEMSX_ILLEGAL_ZERO_EN
         default: w_ext_next = 32'h0000_0000;
`else
         default: w_ext_next = mem_value;
`endif
      endcase
   end

   // Reset takes priority and discards whatever value was in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ext_reg <= 32'h0000_0000;
      end else begin
         r_ext_reg <= w_ext_next;
      end
   end

   assign mem_extend = r_ext_reg;

endmodule

// File: tb/tb_mem_sx.sv
// -----------------------------------------------------------------------------
// tb_mem_sx : bench for mem_sx
// The driver applies one vector per cycle on the falling edge. It also pushes
// the hand-computed expected output into a queue. The monitor samples
// mem_extend 1 ns after each rising edge and compares it with the queue head.
// -----------------------------------------------------------------------------
module tb_mem_sx;

   logic        clk;
   logic        reset;
   logic [2:0]  mem_size;
   logic [31:0] mem_value;
   logic [31:0] mem_extend;

   logic [31:0] exp_q[$];
   string       name_q[$];
   int          total;
   int          bad;

   mem_sx dut (
      .clk        (clk),
      .reset      (reset),
      .mem_size   (mem_size),
      .mem_value  (mem_value),
      .mem_extend (mem_extend)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: one comparison for each vector the driver issued.
   initial begin
      logic [31:0] exp;
      string       nm;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            nm  = name_q.pop_front();
            total++;
            if (mem_extend !== exp) begin
               bad++;
               $display("FAIL %s: got=%08h want=%08h", nm, mem_extend, exp);
            end else begin
               $display("ok   %s: got=%08h", nm, mem_extend);
            end
         end
      end
   end

   task automatic drive(input logic rst, input logic [2:0] sz,
                        input logic [31:0] val, input logic [31:0] exp,
                        input string nm);
      @(negedge clk);
      reset     = rst;
      mem_size  = sz;
      mem_value = val;
      exp_q.push_back(exp);
      name_q.push_back(nm);
   endtask

   initial begin
      logic [31:0] ill_exp;
      int          wait_cyc;
      total     = 0;
      bad       = 0;
      reset     = 1'b1;
      mem_size  = 3'd2;
      mem_value = 32'hDEAD_BEEF;

      // Reset is held for two cycles with live data on the inputs.
      drive(1'b1, 3'd2, 32'hDEAD_BEEF, 32'h0000_0000, "reset0");
      drive(1'b1, 3'd2, 32'hDEAD_BEEF, 32'h0000_0000, "reset1");
      drive(1'b0, 3'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "post_reset_lw");

      // Signed byte loads.
      drive(1'b0, 3'd0, 32'h1234_5680, 32'hFFFF_FF80, "lb_neg");
      drive(1'b0, 3'd0, 32'hFFFF_FF7F, 32'h0000_007F, "lb_pos");
      // Signed halfword loads.
      drive(1'b0, 3'd1, 32'h0000_8001, 32'hFFFF_8001, "lh_neg");
      drive(1'b0, 3'd1, 32'hFFFF_7FFF, 32'h0000_7FFF, "lh_pos");
      // Unsigned loads.
      drive(1'b0, 3'd4, 32'hABCD_EF89, 32'h0000_0089, "lbu");
      drive(1'b0, 3'd5, 32'hABCD_EF89, 32'h0000_EF89, "lhu");

      // Back-to-back codes on one value.
      drive(1'b0, 3'd0, 32'h8765_C3A1, 32'hFFFF_FFA1, "b2b_lb");
      drive(1'b0, 3'd1, 32'h8765_C3A1, 32'hFFFF_C3A1, "b2b_lh");
      drive(1'b0, 3'd2, 32'h8765_C3A1, 32'h8765_C3A1, "b2b_lw");
      drive(1'b0, 3'd4, 32'h8765_C3A1, 32'h0000_00A1, "b2b_lbu");
      drive(1'b0, 3'd5, 32'h8765_C3A1, 32'h0000_C3A1, "b2b_lhu");

      // Upper bits must not leak into byte or halfword results.
      drive(1'b0, 3'd0, 32'h0000_0000, 32'h0000_0000, "lb_zero");
      drive(1'b0, 3'd4, 32'hFFFF_FF00, 32'h0000_0000, "lbu_upper_ones");
      drive(1'b0, 3'd5, 32'hFFFF_0000, 32'h0000_0000, "lhu_upper_ones");
      drive(1'b0, 3'd1, 32'h5555_FFFF, 32'hFFFF_FFFF, "lh_all_ones");
      drive(1'b0, 3'd0, 32'h0000_0080, 32'hFFFF_FF80, "lb_min");
      drive(1'b0, 3'd2, 32'h0000_0000, 32'h0000_0000, "lw_zero");

      // Illegal codes.
`ifdef MEMSX_ILLEGAL_ZERO_EN
      ill_exp = 32'h0000_0000;
      drive(1'b0, 3'd3, 32'h1357_9BDF, ill_exp, "illegal3");
      drive(1'b0, 3'd6, 32'h2468_ACE0, 32'h0000_0000, "illegal6");
      drive(1'b0, 3'd7, 32'hFFFF_FFFF, 32'h0000_0000, "illegal7");
`else
      ill_exp = 32'h1357_9BDF;
      drive(1'b0, 3'd3, 32'h1357_9BDF, ill_exp, "illegal3");
      drive(1'b0, 3'd6, 32'h2468_ACE0, 32'h2468_ACE0, "illegal6");
      drive(1'b0, 3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "illegal7");
`endif

      // Reset asserted mid-stream drops the in-flight value. The next cycle
      // then resumes normally.
      drive(1'b0, 3'd1, 32'h0000_9000, 32'hFFFF_9000, "pre_midreset");
      drive(1'b1, 3'd2, 32'hCAFE_F00D, 32'h0000_0000, "midreset");
      drive(1'b0, 3'd0, 32'hCAFE_F0FE, 32'hFFFF_FFFE, "after_midreset");
      drive(1'b0, 3'd5, 32'h1111_8888, 32'h0000_8888, "lhu_last");

      // Let the monitor drain the queue, with a bounded wait.
      wait_cyc = 0;
      while (exp_q.size() > 0 && wait_cyc < 20) begin
         @(posedge clk);
         wait_cyc++;
      end
      #2;
      if (exp_q.size() > 0) begin
         bad++;
         total++;
         $display("FAIL drain: pending=%0d want=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
